// File: rtl/led_matrix_pkg.sv
// Shared constants and types for the 4x4 LED matrix scan link.
// The serializer and the matrix driver both import this package.
package led_matrix_pkg;

   localparam int LED_FRAME_BITS = 16;
   localparam int LED_SLOTS      = 17;
   localparam int LED_SLOT_W     = 5;

   typedef logic [LED_FRAME_BITS-1:0] led_frame_t;
   typedef logic [LED_SLOT_W-1:0]     led_slot_t;

   // Next scan slot; anything at or above the last slot folds back to 0,
   // so the counter can never wander into the unused codes 17..31.
   function automatic led_slot_t next_slot(input led_slot_t s);
      if (s >= led_slot_t'(LED_SLOTS - 1))
         return '0;
      else
         return s + led_slot_t'(1);
   endfunction

endpackage

// File: rtl/led_frame_serializer_scan_slot_counter.sv
// Free-running 0..LED_SLOTS-1 scan slot counter with first/last slot strobes.
module scan_slot_counter
   import led_matrix_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   output led_slot_t slot,
   output logic      last_slot,
   output logic      first_slot
);

   led_slot_t slot_reg;

   // Advance one slot per clock, wrapping after the last slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         slot_reg <= '0;
      else
         slot_reg <= next_slot(slot_reg);
   end

   assign slot       = slot_reg;
   assign last_slot  = (slot_reg == led_slot_t'(LED_SLOTS - 1));
   assign first_slot = (slot_reg == '0);

endmodule

// File: rtl/led_frame_serializer.sv
// Double-buffered 16-pixel frame serializer for the single-wire LED link.
// Slot 0 is a blank/sync slot, slots 1..16 carry pixels 0..15. A new host
// frame waits in the shadow buffer and only replaces the active frame on
// the 16->0 boundary, so a scan never mixes two frames.
module led_frame_serializer
   import led_matrix_pkg::*;
#(
   parameter int FRAME_BITS = 16,
   parameter int SLOTS      = 17
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FRAME_BITS-1:0] frame_in,
   input  logic                  frame_valid,
   output logic                  frame_ready,
   input  logic                  enable,
   output logic                  data_led,
   output logic                  frame_start,
   output logic [LED_SLOT_W-1:0] slot
);

   // The slot decode and pixel indexing assume the fixed 4x4 geometry.
   generate
      if (FRAME_BITS != LED_FRAME_BITS || SLOTS != LED_SLOTS) begin : g_bad_geometry
         $error("led_frame_serializer supports only a 16-pixel, 17-slot frame");
      end
   endgenerate

   led_slot_t  slot_cur;
   logic       last_slot;
   logic       first_slot;

   led_frame_t active_reg;
   led_frame_t shadow_reg;
   logic       pending_reg;
   logic       data_led_reg;
   logic       data_led_next;

   logic       accept;
   logic       swap;

   scan_slot_counter u_slot_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .slot       (slot_cur),
      .last_slot  (last_slot),
      .first_slot (first_slot)
   );

   // Accept needs an empty shadow and swap needs a full one, so the two
   // can never coincide on the same edge.
   assign accept = frame_valid & ~pending_reg;
   assign swap   = last_slot & pending_reg;

   // Host handshake into the shadow buffer and boundary swap into active.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_reg  <= '0;
         shadow_reg  <= '0;
         pending_reg <= 1'b0;
      end else if (accept) begin
         shadow_reg  <= frame_in;
         pending_reg <= 1'b1;
      end else if (swap) begin
         active_reg  <= shadow_reg;
         pending_reg <= 1'b0;
      end
   end

   // Pixel for the slot being entered: the current slot index s selects
   // pixel s for slot s+1; entering slot 0 always blanks. A swap on the
   // 16->0 edge is therefore visible from slot 1 onward.
   always_comb begin
      data_led_next = 1'b0;
      if (!last_slot)
         data_led_next = active_reg[slot_cur[LED_SLOT_W-2:0]] & enable;
   end

   // Registered output so no input reaches data_led combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         data_led_reg <= 1'b0;
      else
         data_led_reg <= data_led_next;
   end

   assign data_led    = data_led_reg;
   assign frame_ready = ~pending_reg;
   assign frame_start = first_slot;
   assign slot        = slot_cur;

endmodule

// File: tb/tb_led_frame_serializer.sv
// Self-checking bench for led_frame_serializer: an edge-counting reference
// model checked every cycle, plus directed literal checks.
module tb_led_frame_serializer;
   import led_matrix_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] frame_in = '0;
   logic        frame_valid = 1'b0;
   logic        enable = 1'b1;
   logic        frame_ready;
   logic        data_led;
   logic        frame_start;
   logic [4:0]  slot;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   // Reference model state
   int          m_cnt;
   logic [15:0] m_act, m_sh;
   bit          m_pend;
   bit          m_data;
   int          m_nxt;
   bit          m_acc;

   led_frame_serializer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_in    (frame_in),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .enable      (enable),
      .data_led    (data_led),
      .frame_start (frame_start),
      .slot        (slot)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: slot is the edge count since reset modulo 17; buffers follow
   // the accept/swap rules; the output is the pixel of the slot entered.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  = 0;
         m_act  = '0;
         m_sh   = '0;
         m_pend = 1'b0;
         m_data = 1'b0;
      end else begin
         m_acc = frame_valid && !m_pend;
         if (m_acc) begin
            m_sh   = frame_in;
            m_pend = 1'b1;
         end else if ((m_cnt % 17) == 16 && m_pend) begin
            m_act  = m_sh;
            m_pend = 1'b0;
         end
         m_cnt = m_cnt + 1;
         m_nxt = m_cnt % 17;
         m_data = (m_nxt == 0) ? 1'b0 : (m_act[m_nxt-1] & enable);
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en && rst_n) begin
         chk("slot", slot, m_cnt % 17);
         chk("frame_start", frame_start, (m_cnt % 17) == 0);
         chk("data_led", data_led, m_data);
         chk("frame_ready", frame_ready, !m_pend);
      end
   end

   task automatic wait_slot(input int s);
      int n = 0;
      while (slot !== 5'(s) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("wait_slot", slot, s);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (frame_ready !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("wait_ready", frame_ready, 1);
   endtask

   bit a5_exp [17] = '{0, 1,1,0,0,0,0,1,1, 1,0,1,0,0,1,0,1};

   initial begin
      // Reset state
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_slot", slot, 0);
      chk("rst_frame_start", frame_start, 1);
      chk("rst_data_led", data_led, 0);
      chk("rst_frame_ready", frame_ready, 1);
      rst_n = 1'b1;
      cmp_en = 1'b1;
      @(negedge clk);
      chk("first_edge_slot", slot, 1);

      // Idle scan, no frame loaded
      repeat (40) @(negedge clk);

      // Load A5C3 while in slot 3
      wait_slot(3);
      frame_in = 16'hA5C3;
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
      chk("ready_after_accept", frame_ready, 0);
      wait_slot(0);
      for (int s = 0; s < 17; s++) begin
         chk("a5c3_stream", data_led, a5_exp[s]);
         @(negedge clk);
      end

      // FFFF then 0001 offered back to back; second must stall
      wait_ready();
      frame_in = 16'hFFFF;
      frame_valid = 1'b1;
      @(negedge clk);
      frame_in = 16'h0001;
      chk("stall_ready", frame_ready, 0);
      begin
         int n = 0;
         while (frame_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
         end
      end
      @(negedge clk);
      frame_valid = 1'b0;

      // 8000 offered exactly on the 16->0 edge
      wait_ready();
      wait_slot(16);
      frame_in = 16'h8000;
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
      wait_slot(16);
      chk("8000_current_frame", data_led, 0);
      @(negedge clk);
      wait_slot(16);
      chk("8000_next_frame", data_led, 1);

      // Enable gap in slots 5..9 with an all-ones frame
      frame_in = 16'hFFFF;
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
      wait_ready();
      wait_slot(0);
      for (int s = 0; s < 17; s++) begin
         chk("enable_gap", data_led, (s == 0 || (s >= 5 && s <= 9)) ? 0 : 1);
         if (s == 4) enable = 1'b0;
         if (s == 9) enable = 1'b1;
         @(negedge clk);
      end

      // Randomized traffic
      repeat (600) begin
         @(negedge clk);
         frame_valid = ($urandom_range(0, 3) == 0);
         frame_in    = 16'($urandom);
         enable      = ($urandom_range(0, 7) != 0);
      end
      @(negedge clk);
      frame_valid = 1'b0;
      enable = 1'b1;

      // Mid-frame reset with a frame pending
      wait_ready();
      frame_in = 16'hFFFF;
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
      wait_ready();
      frame_in = 16'h1234;
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
      chk("pending_before_reset", frame_ready, 0);
      wait_slot(10);
      chk("led_before_reset", data_led, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_data_led", data_led, 0);
      chk("async_rst_slot", slot, 0);
      chk("async_rst_ready", frame_ready, 1);
      chk("async_rst_frame_start", frame_start, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("restart_slot", slot, 1);
      repeat (20) begin
         @(negedge clk);
         chk("post_reset_zero", data_led, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
